if_fetch_queue: RTL and testbench

//   Instruction-fetch front end. Drives ce/addr into the combinational instruction ROM.

---
 rtl/if_fetch_queue.sv | 131 +++++++++++++
 tb/tb_if_fetch_queue.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the PC, reads the combinational instruction ROM,
// queues {pc, inst} pairs and hands the head entry to decode over valid/ready.
module if_fetch_queue #(
    parameter int unsigned      ADDR_W   = 32,
    parameter int unsigned      INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned      QDEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [INST_W-1:0] rom_inst_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] new_pc_i,
    input  logic              id_ready_i,
    output logic              id_valid_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o
);

    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Redirect targets are silently word-aligned rather than faulted.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

    logic [ADDR_W-1:0] pc_r;
    logic              ce_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [ADDR_W-1:0] mem_pc_r   [QDEPTH];
    logic [INST_W-1:0] mem_inst_r [QDEPTH];

    logic [ADDR_W-1:0] pc_next_s;
    logic [PTR_W-1:0]  rd_ptr_next_s;
    logic [PTR_W-1:0]  wr_ptr_next_s;
    logic [CNT_W-1:0]  count_next_s;
    logic              not_full_s;
    logic              pop_s;
    logic              push_s;

    assign rom_ce_o   = ce_r;
    assign rom_addr_o = pc_r;
    assign id_valid_o = (count_r != {CNT_W{1'b0}});
    assign not_full_s = (count_r < CNT_W'(QDEPTH));
    assign pop_s      = id_valid_o & id_ready_i;
    // A full queue may still accept a fetch when the head leaves in the same cycle.
    assign push_s     = ce_r & ~branch_flag_i & ~flush_i & (not_full_s | pop_s);

    // Head entry presented to decode, forced to zero when the queue is empty.
    always_comb begin
        id_pc_o   = {ADDR_W{1'b0}};
        id_inst_o = {INST_W{1'b0}};
        if (id_valid_o) begin
            id_pc_o   = mem_pc_r[rd_ptr_r];
            id_inst_o = mem_inst_r[rd_ptr_r];
        end else begin
            id_pc_o   = {ADDR_W{1'b0}};
            id_inst_o = {INST_W{1'b0}};
        end
    end

    // Next PC and queue bookkeeping; flush outranks branch, which outranks fetch.
    always_comb begin
        pc_next_s     = pc_r;
        rd_ptr_next_s = rd_ptr_r;
        wr_ptr_next_s = wr_ptr_r;
        count_next_s  = count_r;
        if (flush_i) begin
            pc_next_s     = align_pc(new_pc_i);
            rd_ptr_next_s = {PTR_W{1'b0}};
            wr_ptr_next_s = {PTR_W{1'b0}};
            count_next_s  = {CNT_W{1'b0}};
        end else if (branch_flag_i) begin
            pc_next_s     = align_pc(branch_target_i);
            rd_ptr_next_s = {PTR_W{1'b0}};
            wr_ptr_next_s = {PTR_W{1'b0}};
            count_next_s  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                pc_next_s     = pc_r + ADDR_W'(4);
                wr_ptr_next_s = wr_ptr_r + PTR_W'(1);
            end else begin
                pc_next_s     = pc_r;
                wr_ptr_next_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_next_s = rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_next_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_next_s = count_r + CNT_W'(1);
                2'b01:   count_next_s = count_r - CNT_W'(1);
                default: count_next_s = count_r;
            endcase
        end
    end

    // Control state: PC, fetch enable and queue pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r     <= RESET_PC;
            ce_r     <= 1'b0;
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            pc_r     <= pc_next_s;
            ce_r     <= 1'b1;
            rd_ptr_r <= rd_ptr_next_s;
            wr_ptr_r <= wr_ptr_next_s;
            count_r  <= count_next_s;
        end
    end

    // Queue storage; contents are only meaningful between rd_ptr and wr_ptr.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_pc_r[wr_ptr_r]   <= pc_r;
            mem_inst_r[wr_ptr_r] <= rom_inst_i;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomised and directed checks of if_fetch_queue against a queue-based fetch model.
module tb_if_fetch_queue;

    localparam int QD = 4;

    logic        clk;
    logic        rst_n;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_inst_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic        id_ready_i;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic        m_ce;
    int          n_cmp;
    int          n_err;

    if_fetch_queue #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0000_0000), .QDEPTH(QD)) dut (
        .clk(clk), .rst_n(rst_n), .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o),
        .rom_inst_i(rom_inst_i), .branch_flag_i(branch_flag_i),
        .branch_target_i(branch_target_i), .flush_i(flush_i), .new_pc_i(new_pc_i),
        .id_ready_i(id_ready_i), .id_valid_o(id_valid_o), .id_pc_o(id_pc_o),
        .id_inst_o(id_inst_o)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    assign rom_inst_i = rom_word(rom_addr_o);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("rom_ce", {31'd0, rom_ce_o}, {31'd0, m_ce});
        chk("rom_addr", rom_addr_o, m_pc);
        chk("id_valid", {31'd0, id_valid_o}, {31'd0, (mq.size() != 0)});
        chk("id_pc", id_pc_o, (mq.size() != 0) ? mq[0].pc : 32'd0);
        chk("id_inst", id_inst_o, (mq.size() != 0) ? mq[0].inst : 32'd0);
    endtask

    // Called at a falling edge: apply inputs, advance the model across the next rising edge, check.
    task automatic step(input logic br, input logic [31:0] bt, input logic fl,
                        input logic [31:0] np, input logic rdy);
        bit pop;
        bit room;
        branch_flag_i   = br;
        branch_target_i = bt;
        flush_i         = fl;
        new_pc_i        = np;
        id_ready_i      = rdy;
        pop  = (mq.size() != 0) && rdy;
        room = (mq.size() < QD) || pop;
        if (fl) begin
            mq.delete();
            m_pc = {np[31:2], 2'b00};
        end else if (br) begin
            mq.delete();
            m_pc = {bt[31:2], 2'b00};
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_ce && room) begin
                mq.push_back('{pc: m_pc, inst: rom_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
        m_ce = 1'b1;
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 32'd0, rdy);
    endtask

    // Asserts reset away from any clock edge, checks outputs clear at once, then releases.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", {31'd0, id_valid_o}, 32'd0);
        chk("rst_pc", id_pc_o, 32'd0);
        chk("rst_inst", id_inst_o, 32'd0);
        chk("rst_addr", rom_addr_o, 32'd0);
        chk("rst_ce", {31'd0, rom_ce_o}, 32'd0);
        mq.delete();
        m_pc = 32'd0;
        m_ce = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        compare_all();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        branch_flag_i = 1'b0;
        branch_target_i = 32'd0;
        flush_i = 1'b0;
        new_pc_i = 32'd0;
        id_ready_i = 1'b0;
        m_pc = 32'd0;
        m_ce = 1'b0;
        @(negedge clk);
        async_reset();

        // Start-up and steady streaming
        step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        chk("t1_ce_first", {31'd0, rom_ce_o}, 32'd1);
        chk("t1_valid_early", {31'd0, id_valid_o}, 32'd0);
        step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        chk("t1_first_pc", id_pc_o, 32'd0);
        idle(5, 1'b1);

        // Backpressure, then full+pop in the same cycle
        async_reset();
        idle(6, 1'b0);
        chk("t2_addr_hold", rom_addr_o, 32'h10);
        chk("t2_head", id_pc_o, 32'h0);
        step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        chk("t3_head", id_pc_o, 32'h4);
        chk("t3_tail", mq[QD-1].pc, 32'h10);
        idle(6, 1'b1);

        // Branch with three entries queued
        async_reset();
        idle(4, 1'b0);
        step(1'b1, 32'h103, 1'b0, 32'd0, 1'b0);
        chk("t4_valid", {31'd0, id_valid_o}, 32'd0);
        chk("t4_addr", rom_addr_o, 32'h100);
        step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        chk("t4_head", id_pc_o, 32'h100);

        // Flush beats branch
        idle(2, 1'b0);
        step(1'b1, 32'h40, 1'b1, 32'h180, 1'b1);
        chk("t5_addr", rom_addr_o, 32'h180);
        chk("t5_valid", {31'd0, id_valid_o}, 32'd0);
        idle(3, 1'b1);

        // PC wrap, then reset with two entries queued
        step(1'b0, 32'd0, 1'b1, 32'hFFFF_FFFE, 1'b1);
        chk("t6_top", rom_addr_o, 32'hFFFF_FFFC);
        step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        chk("t6_wrap", rom_addr_o, 32'h0);
        step(1'b1, 32'h200, 1'b0, 32'd0, 1'b0);
        idle(2, 1'b0);
        async_reset();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic        br;
            logic        fl;
            logic        rdy;
            logic [31:0] bt;
            logic [31:0] np;
            br  = ($urandom_range(15) == 0);
            fl  = ($urandom_range(19) == 0);
            rdy = ($urandom_range(2) != 0);
            bt  = $urandom;
            np  = $urandom;
            step(br, bt, fl, np, rdy);
            if ($urandom_range(99) == 0) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
